// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared PHY definitions: character width, comma/idle code, alignment
// threshold and receive FSM encodings.
package serial_to_parallel_rx_pkg;

    localparam int          WIDTH     = 8;
    localparam logic [7:0]  COM       = 8'hBC;
    localparam int          COM_COUNT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Serial-in / byte-out link between the deserializer and its neighbours.
// The master side drives the serial bit; the slave (the receiver) returns
// the aligned byte, its data flag and the link-active indication.
interface serial_to_parallel_rx_if #(
    parameter int WIDTH = serial_to_parallel_rx_pkg::WIDTH
);
    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             active;

    modport master (output data_in, input data_out, valid_out, active);
    modport slave  (input data_in, output data_out, valid_out, active);
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Receive deserializer: hunts for the comma character on every bit, locks
// byte boundaries once COM_COUNT consecutive aligned commas are seen, then
// presents each aligned byte for a full byte period. Commas are marked
// invalid so the unstriping stage only sees data.
module serial_to_parallel_rx
    import serial_to_parallel_rx_pkg::*;
#(
    parameter int               WIDTH     = serial_to_parallel_rx_pkg::WIDTH,
    parameter logic [WIDTH-1:0] COM       = serial_to_parallel_rx_pkg::COM,
    parameter int               COM_COUNT = serial_to_parallel_rx_pkg::COM_COUNT
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_to_parallel_rx_if.slave  rx
);

    localparam int BCW = $clog2(WIDTH);
    localparam int CCW = $clog2(COM_COUNT + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    rx_state_e          state_q, state_d;
    logic [WIDTH-2:0]   sreg_q, sreg_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CCW-1:0]     com_cnt_q, com_cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               active_q, active_d;

    logic [WIDTH-1:0]   cand;
    logic               is_com;
    logic               boundary;

    // The byte completed by this edge's bit: 7 bits of history plus the new one.
    assign cand     = {sreg_q, rx.data_in};
    assign is_com   = (cand == COM);
    assign boundary = (bit_cnt_q == BIT_LAST);
    assign sreg_d   = cand[WIDTH-2:0];

    // Next-state and output decode for the alignment FSM.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;

        case (state_q)
            SEARCH: begin
                // No boundary yet: a match anywhere defines the boundary and
                // counts as the first comma of the run.
                bit_cnt_d = '0;
                if (is_com) begin
                    com_cnt_d = CCW'(1);
                    if (COM_COUNT == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 1'b1;
                        if (com_cnt_q == CCW'(COM_COUNT - 1)) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Alignment is trusted from here on; only reset leaves this state.
                if (boundary) begin
                    data_d  = cand;
                    valid_d = !is_com;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, forcing a fresh search.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SEARCH;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign rx.data_out  = data_q;
    assign rx.valid_out = valid_q;
    assign rx.active    = active_q;

endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Receive-side deserializer of the PHY. Takes the 1-bit serial stream produced by the transmit parallel-to-serial stage, finds byte alignment on the 0xBC comma, declares the link active after four consecutive aligned commas, and then delivers 8-bit bytes with a valid flag to the byte-unstriping stage. Idle commas are consumed here and never flagged valid downstream.

## Interface

Parameters:
- `WIDTH`, 8: byte width.
- `COM`, 8'hBC: comma/idle character.
- `COM_COUNT`, 4: consecutive aligned commas required to go active.

Ports:
- `clk`  in  1: serial bit clock; one bit per rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `data_in`  in  1: serial data, MSB of each byte first.
- `data_out`  out  WIDTH: last completed aligned byte, held for a full byte period.
- `valid_out`  out  1: data_out is a data byte, not a comma; held with data_out.
- `active`  out  1: alignment achieved; sticky until reset.

## Operation

- Internal state: shift register `sreg` (WIDTH-1 bits of history), 3-bit bit counter `bit_cnt`, comma counter `com_cnt` (0..COM_COUNT), FSM {SEARCH, ALIGN, ACTIVE}.
- Every edge: `sreg <= {sreg[WIDTH-3:0], data_in}`; candidate byte `cand = {sreg, data_in}`.
- SEARCH: compare cand to COM every edge, with no byte boundary. On match: `bit_cnt <= 0`, `com_cnt <= 1`, go to ALIGN. The match edge is the boundary.
- ALIGN: `bit_cnt` increments and wraps 7->0. Boundary when `bit_cnt == 7`. At a boundary, if cand == COM: `com_cnt++`. When `com_cnt` reaches COM_COUNT, go to ACTIVE and set `active`. If cand != COM: `com_cnt <= 0`, go to SEARCH.
- ACTIVE: at each boundary, `data_out <= cand`. Set `valid_out <= (cand != COM)`. Non-comma bytes never drop alignment. ACTIVE is left only by reset.
- Outside ACTIVE: `data_out` and `valid_out` stay at their reset values.
- Reset (reset == 0, any time including mid-byte):
  - state SEARCH; `sreg`, `bit_cnt`, `com_cnt` = 0.
  - `data_out` = 0, `valid_out` = 0, `active` = 0.
  - Recovery requires a fresh comma search.

## Timing

- Boundary byte is registered at the edge that samples its 8th bit. data_out/valid_out change on that edge and hold exactly 8 clk cycles, until the next boundary. This lets a clk/8 consumer sample safely.
- `active` rises on the edge that samples the last bit of the COM_COUNT-th aligned comma. The first data byte can appear at the next boundary, 8 edges later.
- Minimum time to active from reset release: 8 × COM_COUNT = 32 edges, given a clean comma stream.
- Simultaneous events:
  - A comma match in SEARCH is counted as comma #1. Misaligned 0xBC-like patterns straddling a boundary in ALIGN/ACTIVE are ignored.
  - Reset assertion overrides every transition asynchronously.

## Structure

- Shared PHY package/include: `COM` (8'hBC), `COM_COUNT`, `WIDTH`, and the FSM state encodings. These are shared with the transmit serializer and the unstriping stage.
- Single flat module. A separate sub-module is not warranted.

## Test plan

1. Reset held low for 5 edges with toggling data_in. Required: data_out = 0x00, valid_out = 0, active = 0 throughout, and immediately on reset assertion mid-byte.
2. Stream 4×0xBC then 0xFF, 0xF4, 0xE8. Required:
   - `active` rises on the 32nd edge.
   - data_out = 0xFF, valid_out = 1 at the boundary 8 edges later, held 8 edges.
   - Then 0xF4, then 0xE8.
3. Stream 3 bits of junk (101), then 4×0xBC, 0x7F. Required: alignment found at the 3+8th edge; active at edge 35; data_out = 0x7F, valid_out = 1.
4. Stream 2×0xBC, 0x55, 4×0xBC, 0xD4. Required:
   - Return to SEARCH at the 0x55 boundary; active stays 0.
   - active rises after the second comma run.
   - data_out = 0xD4, valid_out = 1.
5. While ACTIVE, send 0xBC, 0x8C, 0xBC. Required: data_out = 0xBC/valid_out = 0, then 0x8C/1, then 0xBC/0; active stays 1.
6. Assert reset for 1 cycle mid-byte while ACTIVE. Required: all outputs zero at once; after release, data bytes are not flagged until 4 new aligned commas are seen.
